instr_fetch_unit: RTL and testbench

//  Read-side companion of instruction_mem. Walks memory byte addresses, issues 1-cycle-latency byte

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 53 +++++
 rtl/instr_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-unit types and constants: FSM state encoding, halt opcode, bytes per instruction.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_HI,
    RD_LO
  } fetch_state_e;

  localparam logic [15:0] HALT_OPCODE = 16'hFFFF;
  localparam int unsigned INSTR_BYTES = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH x W entries, synchronous push/pop, occupancy count and flush.
module fetch_fifo #(
  parameter int unsigned W     = 24,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count != (AW+1)'(DEPTH)) || do_pop);
  // Empty buffer presents zero so a flushed or reset unit shows instr=0.
  assign pop_data = (count == '0) ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Byte-wise instruction fetch: FSM, PC and {hi,lo} assembly feeding fetch_fifo.
// Optional halt-on-0xFFFF behaviour is enabled by defining FETCH_HALT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned DEPTH   = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [7:0]         mem_rdata,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               halted
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned FW = ADDR_W + INSTR_W;

  fetch_state_e       state, state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  tag_pc;
  logic [7:0]         hi_byte;
  logic               hi_due;
  logic               lo_due;
  logic               inflight;
  logic               issue_hi;
  logic               issue_lo;
  logic               fetch_ok;
  logic               pop;
  logic               space;
  logic [CW-1:0]      count;
  logic [CW:0]        occ;
  logic [INSTR_W-1:0] assembled;
  logic [FW-1:0]      head;

  assign assembled   = {hi_byte, mem_rdata};
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign instr_pc    = head[FW-1 -: ADDR_W];
  assign instr       = head[INSTR_W-1:0];

  // A pop this cycle already frees a slot, so fetch resumes one cycle after the pop.
  assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign space = occ < (CW+1)'(DEPTH);

`ifdef FETCH_HALT_EN
  logic halt_seen;
  logic halt_push;

  // Gate the next read combinationally so nothing is fetched past the halt opcode.
  assign halt_push = lo_due && (assembled == HALT_OPCODE);
  assign fetch_ok  = run && !halt_seen && !halt_push;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      halt_seen <= 1'b0;
      halted    <= 1'b0;
    end else if (redirect) begin
      halt_seen <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if (halt_push) halt_seen <= 1'b1;
      if (pop && halt_seen && (instr == HALT_OPCODE)) halted <= 1'b1;
    end
  end
`else
  assign fetch_ok = run;
  assign halted   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    issue_hi  = 1'b0;
    issue_lo  = 1'b0;
    mem_addr  = pc;
    case (state)
      IDLE:  if (fetch_ok && space) state_nxt = RD_HI;
      RD_HI: begin
        if (fetch_ok) begin
          issue_hi  = 1'b1;
          state_nxt = RD_LO;
        end else begin
          state_nxt = IDLE;
        end
      end
      RD_LO: begin
        issue_lo  = 1'b1;
        mem_addr  = pc | ADDR_W'(1);
        state_nxt = (fetch_ok && space) ? RD_HI : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (redirect) begin
      issue_hi  = 1'b0;
      issue_lo  = 1'b0;
      state_nxt = IDLE;
    end
    mem_rd_en = issue_hi || issue_lo;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= '0;
      tag_pc   <= '0;
      hi_byte  <= '0;
      hi_due   <= 1'b0;
      lo_due   <= 1'b0;
      inflight <= 1'b0;
    end else if (redirect) begin
      state    <= IDLE;
      pc       <= redirect_addr & ~ADDR_W'(1);
      hi_byte  <= '0;
      hi_due   <= 1'b0;
      lo_due   <= 1'b0;
      inflight <= 1'b0;
    end else begin
      state  <= state_nxt;
      hi_due <= issue_hi;
      lo_due <= issue_lo;
      if (issue_hi) tag_pc  <= pc;
      if (hi_due)   hi_byte <= mem_rdata;
      if (issue_lo) pc      <= pc + ADDR_W'(INSTR_BYTES);
      if (issue_hi)    inflight <= 1'b1;
      else if (lo_due) inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect),
    .push      (lo_due),
    .push_data ({tag_pc, assembled}),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit paired with a 1-cycle-latency byte memory model.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] ins;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        run;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        halted;

  logic [7:0] mem [256];
  exp_t       exp_q[$];
  int         rd_log[$];
  int         rd_cyc[$];
  int         hs_cyc[$];
  int         cyc;
  int         n_checks;
  int         n_err;

  instr_fetch_unit #(
    .ADDR_W  (8),
    .INSTR_W (16),
    .DEPTH   (2)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .mem_rd_en     (mem_rd_en),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .halted        (halted)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (mem_rd_en) begin
        rd_log.push_back(int'(mem_addr));
        rd_cyc.push_back(cyc);
      end
      if (instr_valid && instr_ready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("sb_nonempty", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_pc", int'(instr_pc), int'(e.pc));
          check("sb_instr", int'(instr), int'(e.ins));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    rd_log.delete();
    rd_cyc.delete();
    hs_cyc.delete();
  endtask

  task automatic push_exp(input logic [7:0] start, input int n);
    logic [7:0] a;
    exp_t e;
    a = start;
    for (int i = 0; i < n; i++) begin
      e.pc  = a;
      e.ins = {mem[a], mem[8'(a + 8'd1)]};
      exp_q.push_back(e);
      a = a + 8'd2;
    end
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    clear_logs();
    push_exp(8'h00, 32);
  endtask

  task automatic redirect_to(input logic [7:0] a);
    @(posedge clock); #1;
    redirect      = 1'b1;
    redirect_addr = a;
    @(negedge clock);
    check("redir_rd_en", int'(mem_rd_en), 0);
    tick(1);
    redirect = 1'b0;
    clear_logs();
    push_exp(a & 8'hFE, 32);
  endtask

  task automatic wait_rd(input logic odd, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (mem_rd_en && (mem_addr[0] == odd)) ok = 1'b1;
    end
    check(tag, int'(ok), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_err         = 0;
    cyc           = 0;
    reset         = 1'b1;
    run           = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    instr_ready   = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    // Reset values
    tick(3);
    @(negedge clock);
    check("rst_rd_en", int'(mem_rd_en), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_instr", int'(instr), 0);
    check("rst_pc", int'(instr_pc), 0);
    check("rst_valid", int'(instr_valid), 0);
    check("rst_halted", int'(halted), 0);

    // 1: streaming fetch, latency and rate
    tick(1);
    run         = 1'b1;
    instr_ready = 1'b1;
    reset       = 1'b0;
    clear_logs();
    push_exp(8'h00, 32);
    tick(14);
    for (int i = 0; i < 6; i++) check("t1_rd_addr", rd_log[i], i);
    check("t1_latency", hs_cyc[0] - rd_cyc[0], 3);
    check("t1_gap0", hs_cyc[1] - hs_cyc[0], 2);
    check("t1_gap1", hs_cyc[2] - hs_cyc[1], 2);

    // 2: back-pressure fills exactly DEPTH entries, then in-order drain
    instr_ready = 1'b0;
    do_reset();
    tick(12);
    @(negedge clock);
    check("t2_valid", int'(instr_valid), 1);
    check("t2_head", int'(instr), 16'h0001);
    check("t2_head_pc", int'(instr_pc), 0);
    check("t2_rd_idle", int'(mem_rd_en), 0);
    check("t2_nreads", rd_log.size(), 4);
    rd_log.delete();
    rd_cyc.delete();
    hs_cyc.delete();
    tick(1);
    instr_ready = 1'b1;
    tick(8);
    check("t2_resume_addr", rd_log[0], 4);
    check("t2_resume_cyc", rd_cyc[0], hs_cyc[0] + 1);

    // 3: redirect while the hi byte is returning
    wait_rd(1'b0, "t3_wait_hi");
    redirect_to(8'h09);
    tick(12);
    check("t3_rd0", rd_log[0], 8'h08);
    check("t3_rd1", rd_log[1], 8'h09);
    check("t3_progress", int'(hs_cyc.size() > 0), 1);

    // 4: PC wrap 0xFE -> 0x00 without a gap
    redirect_to(8'hFE);
    tick(12);
    check("t4_rd0", rd_log[0], 8'hFE);
    check("t4_rd1", rd_log[1], 8'hFF);
    check("t4_rd2", rd_log[2], 8'h00);
    check("t4_rd3", rd_log[3], 8'h01);
    check("t4_gap", hs_cyc[1] - hs_cyc[0], 2);

    // 5: asynchronous reset in the middle of the lo-byte read
    wait_rd(1'b1, "t5_wait_lo");
    #1 reset = 1'b1;
    #1;
    check("t5_rd_en", int'(mem_rd_en), 0);
    check("t5_addr", int'(mem_addr), 0);
    check("t5_instr", int'(instr), 0);
    check("t5_pc", int'(instr_pc), 0);
    check("t5_valid", int'(instr_valid), 0);
    tick(2);
    reset = 1'b0;
    clear_logs();
    push_exp(8'h00, 32);
    tick(10);
    check("t5_rd0", rd_log[0], 0);
    check("t5_rd1", rd_log[1], 1);

    // 6: 0xFFFF at address 4
    mem[4] = 8'hFF;
    mem[5] = 8'hFF;
    do_reset();
    tick(20);
    @(negedge clock);
`ifdef FETCH_HALT_EN
    check("t6_halted", int'(halted), 1);
    check("t6_nreads", rd_log.size(), 6);
    redirect_to(8'h00);
    @(negedge clock);
    check("t6_halt_clear", int'(halted), 0);
    tick(4);
    check("t6_restart", rd_log[0], 0);
`else
    check("t6_halted", int'(halted), 0);
    check("t6_continues", int'(rd_log.size() > 6), 1);
    check("t6_rd6", rd_log[6], 6);
`endif

    tick(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
